// File: rtl/execution_module.sv
// MIPS execute stage: operand forwarding, ALU, destination select and the
// EX/MEM pipeline register feeding the memory stage.
module execution_module #(
    parameter int NB_BITS       = 32,
    parameter int NB_ALU_OP_CTL = 4,
    parameter int NB_FUNCTION   = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [1:0]               i_mux_a_hz,
    input  logic [1:0]               i_mux_b_hz,
    input  logic [NB_BITS-1:0]       i_ex_mem_reg_hz,
    input  logic [NB_BITS-1:0]       i_mem_wb_reg_hz,
    input  logic [NB_ALU_OP_CTL-1:0] i_alu_op_ctl,
    input  logic [1:0]               i_mux_rs_ctl,
    input  logic                     i_mux_rt_ctl,
    input  logic [1:0]               i_mux_dest_ctl,
    input  logic [4:0]               i_rt,
    input  logic [4:0]               i_rd,
    input  logic [NB_BITS-1:0]       i_sign_ext,
    input  logic [NB_BITS-1:0]       i_rt_reg,
    input  logic [NB_BITS-1:0]       i_rs_reg,
    input  logic [NB_BITS-1:0]       i_pc_4,
    input  logic [NB_FUNCTION-1:0]   i_function,
    input  logic [7:0]               i_wb_ctl,
    input  logic [7:0]               i_mem_ctl,
    output logic [NB_BITS-1:0]       o_alu_out,
    output logic [NB_BITS-1:0]       o_data_reg,
    output logic [4:0]               o_reg_dst,
    output logic [7:0]               o_wb_ctl,
    output logic [7:0]               o_mem_ctl
);

    localparam logic [NB_ALU_OP_CTL-1:0] OP_ADD  = NB_ALU_OP_CTL'(4'b0000);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_SUB  = NB_ALU_OP_CTL'(4'b0001);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_FUNC = NB_ALU_OP_CTL'(4'b0010);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_SLTI = NB_ALU_OP_CTL'(4'b0011);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_AND  = NB_ALU_OP_CTL'(4'b0100);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_OR   = NB_ALU_OP_CTL'(4'b0101);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_XOR  = NB_ALU_OP_CTL'(4'b0110);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_LUI  = NB_ALU_OP_CTL'(4'b0111);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_NONE = NB_ALU_OP_CTL'(4'b1000);
    localparam logic [NB_ALU_OP_CTL-1:0] OP_JAL  = NB_ALU_OP_CTL'(4'b1001);

    localparam logic [NB_FUNCTION-1:0] FN_SLL  = NB_FUNCTION'(6'b000000);
    localparam logic [NB_FUNCTION-1:0] FN_SRL  = NB_FUNCTION'(6'b000010);
    localparam logic [NB_FUNCTION-1:0] FN_SRA  = NB_FUNCTION'(6'b000011);
    localparam logic [NB_FUNCTION-1:0] FN_SLLV = NB_FUNCTION'(6'b000100);
    localparam logic [NB_FUNCTION-1:0] FN_SRLV = NB_FUNCTION'(6'b000110);
    localparam logic [NB_FUNCTION-1:0] FN_SRAV = NB_FUNCTION'(6'b000111);
    localparam logic [NB_FUNCTION-1:0] FN_JR   = NB_FUNCTION'(6'b001000);
    localparam logic [NB_FUNCTION-1:0] FN_JALR = NB_FUNCTION'(6'b001001);
    localparam logic [NB_FUNCTION-1:0] FN_ADDU = NB_FUNCTION'(6'b100001);
    localparam logic [NB_FUNCTION-1:0] FN_SUBU = NB_FUNCTION'(6'b100011);
    localparam logic [NB_FUNCTION-1:0] FN_AND  = NB_FUNCTION'(6'b100100);
    localparam logic [NB_FUNCTION-1:0] FN_OR   = NB_FUNCTION'(6'b100101);
    localparam logic [NB_FUNCTION-1:0] FN_XOR  = NB_FUNCTION'(6'b100110);
    localparam logic [NB_FUNCTION-1:0] FN_NOR  = NB_FUNCTION'(6'b100111);
    localparam logic [NB_FUNCTION-1:0] FN_SLT  = NB_FUNCTION'(6'b101010);

    localparam logic [NB_BITS-1:0] ZERO    = {NB_BITS{1'b0}};
    localparam logic [NB_BITS-1:0] PC_STEP = NB_BITS'(32'd4);

    logic [NB_BITS-1:0] rs_f_s;
    logic [NB_BITS-1:0] rt_f_s;
    logic [NB_BITS-1:0] a_s;
    logic [NB_BITS-1:0] b_s;
    logic [NB_BITS-1:0] func_res_s;
    logic [NB_BITS-1:0] alu_res_s;
    logic [NB_BITS-1:0] slt_s;
    logic [4:0]         shamt_s;
    logic [4:0]         dest_s;

    logic [NB_BITS-1:0] alu_out_r;
    logic [NB_BITS-1:0] data_reg_r;
    logic [4:0]         reg_dst_r;
    logic [7:0]         wb_ctl_r;
    logic [7:0]         mem_ctl_r;

    // Hazard forwarding muxes for rs and rt.
    always_comb begin
        rs_f_s = i_rs_reg;
        rt_f_s = i_rt_reg;
        case (i_mux_a_hz)
            2'b01:   rs_f_s = i_ex_mem_reg_hz;
            2'b10:   rs_f_s = i_mem_wb_reg_hz;
            default: rs_f_s = i_rs_reg;
        endcase
        case (i_mux_b_hz)
            2'b01:   rt_f_s = i_ex_mem_reg_hz;
            2'b10:   rt_f_s = i_mem_wb_reg_hz;
            default: rt_f_s = i_rt_reg;
        endcase
    end

    // Operand and destination-register selection.
    always_comb begin
        a_s    = ZERO;
        b_s    = rt_f_s;
        dest_s = i_rd;
        case (i_mux_rs_ctl)
            2'b00:   a_s = i_pc_4;
            2'b01:   a_s = rs_f_s;
            2'b10:   a_s = i_sign_ext;
            default: a_s = ZERO;
        endcase
        if (i_mux_rt_ctl) begin
            b_s = i_sign_ext;
        end else begin
            b_s = rt_f_s;
        end
        case (i_mux_dest_ctl)
            2'b01:   dest_s = i_rt;
            2'b10:   dest_s = 5'd31;
            default: dest_s = i_rd;
        endcase
    end

    assign shamt_s = a_s[4:0];
    assign slt_s   = {{(NB_BITS-1){1'b0}}, ($signed(a_s) < $signed(b_s))};

    // R-type function decode; variable shifts differ only in how A was selected.
    always_comb begin
        func_res_s = ZERO;
        case (i_function)
            FN_SLL, FN_SLLV: func_res_s = b_s << shamt_s;
            FN_SRL, FN_SRLV: func_res_s = b_s >> shamt_s;
            FN_SRA, FN_SRAV: func_res_s = $unsigned($signed(b_s) >>> shamt_s);
            FN_JR:           func_res_s = ZERO;
            FN_JALR:         func_res_s = a_s + PC_STEP;
            FN_ADDU:         func_res_s = a_s + b_s;
            FN_SUBU:         func_res_s = a_s - b_s;
            FN_AND:          func_res_s = a_s & b_s;
            FN_OR:           func_res_s = a_s | b_s;
            FN_XOR:          func_res_s = a_s ^ b_s;
            FN_NOR:          func_res_s = ~(a_s | b_s);
            FN_SLT:          func_res_s = slt_s;
            default:         func_res_s = ZERO;
        endcase
    end

    // Top-level ALU operation decode.
    always_comb begin
        alu_res_s = ZERO;
        case (i_alu_op_ctl)
            OP_ADD:  alu_res_s = a_s + b_s;
            OP_SUB:  alu_res_s = a_s - b_s;
            OP_FUNC: alu_res_s = func_res_s;
            OP_SLTI: alu_res_s = slt_s;
            OP_AND:  alu_res_s = a_s & b_s;
            OP_OR:   alu_res_s = a_s | b_s;
            OP_XOR:  alu_res_s = a_s ^ b_s;
            OP_LUI:  alu_res_s = b_s << 5'd16;
            OP_NONE: alu_res_s = ZERO;
            OP_JAL:  alu_res_s = a_s + PC_STEP;
            default: alu_res_s = ZERO;
        endcase
    end

    // EX/MEM pipeline register; store data is always the forwarded rt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alu_out_r  <= ZERO;
            data_reg_r <= ZERO;
            reg_dst_r  <= 5'd0;
            wb_ctl_r   <= 8'd0;
            mem_ctl_r  <= 8'd0;
        end else begin
            alu_out_r  <= alu_res_s;
            data_reg_r <= rt_f_s;
            reg_dst_r  <= dest_s;
            wb_ctl_r   <= i_wb_ctl;
            mem_ctl_r  <= i_mem_ctl;
        end
    end

    assign o_alu_out  = alu_out_r;
    assign o_data_reg = data_reg_r;
    assign o_reg_dst  = reg_dst_r;
    assign o_wb_ctl   = wb_ctl_r;
    assign o_mem_ctl  = mem_ctl_r;

endmodule

// File: tb/tb_execution_module.sv
// Directed-vector bench for execution_module with hand-computed expectations.
module tb_execution_module;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_mux_a_hz, i_mux_b_hz;
    logic [31:0] i_ex_mem_reg_hz, i_mem_wb_reg_hz;
    logic [3:0]  i_alu_op_ctl;
    logic [1:0]  i_mux_rs_ctl;
    logic        i_mux_rt_ctl;
    logic [1:0]  i_mux_dest_ctl;
    logic [4:0]  i_rt, i_rd;
    logic [31:0] i_sign_ext, i_rt_reg, i_rs_reg, i_pc_4;
    logic [5:0]  i_function;
    logic [7:0]  i_wb_ctl, i_mem_ctl;
    logic [31:0] o_alu_out, o_data_reg;
    logic [4:0]  o_reg_dst;
    logic [7:0]  o_wb_ctl, o_mem_ctl;

    int vectors = 0;
    int miscompares = 0;

    execution_module dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_mux_a_hz(i_mux_a_hz), .i_mux_b_hz(i_mux_b_hz),
        .i_ex_mem_reg_hz(i_ex_mem_reg_hz), .i_mem_wb_reg_hz(i_mem_wb_reg_hz),
        .i_alu_op_ctl(i_alu_op_ctl), .i_mux_rs_ctl(i_mux_rs_ctl),
        .i_mux_rt_ctl(i_mux_rt_ctl), .i_mux_dest_ctl(i_mux_dest_ctl),
        .i_rt(i_rt), .i_rd(i_rd), .i_sign_ext(i_sign_ext),
        .i_rt_reg(i_rt_reg), .i_rs_reg(i_rs_reg), .i_pc_4(i_pc_4),
        .i_function(i_function), .i_wb_ctl(i_wb_ctl), .i_mem_ctl(i_mem_ctl),
        .o_alu_out(o_alu_out), .o_data_reg(o_data_reg), .o_reg_dst(o_reg_dst),
        .o_wb_ctl(o_wb_ctl), .o_mem_ctl(o_mem_ctl)
    );

    always #5 i_clk = ~i_clk;

    task automatic set_defaults();
        i_rst = 1'b0;
        i_mux_a_hz = 2'b00; i_mux_b_hz = 2'b00;
        i_ex_mem_reg_hz = 32'd0; i_mem_wb_reg_hz = 32'd0;
        i_alu_op_ctl = 4'b0010; i_mux_rs_ctl = 2'b01; i_mux_rt_ctl = 1'b0;
        i_mux_dest_ctl = 2'b00;
        i_rs_reg = 32'd15; i_rt_reg = 32'd7; i_sign_ext = 32'd5; i_pc_4 = 32'd55;
        i_rt = 5'd4; i_rd = 5'd9;
        i_function = 6'b100001;
        i_wb_ctl = 8'h00; i_mem_ctl = 8'h00;
    endtask

    // One edge, then compare all registered outputs.
    task automatic step(input string tag, input logic [31:0] e_alu, input logic [31:0] e_data,
                        input logic [4:0] e_dst, input logic [7:0] e_wb, input logic [7:0] e_mem);
        @(posedge i_clk);
        #1;
        vectors++;
        assert (o_alu_out === e_alu) else begin
            miscompares++;
            $error("FAIL %s alu_out observed=%h expected=%h", tag, o_alu_out, e_alu);
        end
        assert (o_data_reg === e_data) else begin
            miscompares++;
            $error("FAIL %s data_reg observed=%h expected=%h", tag, o_data_reg, e_data);
        end
        assert (o_reg_dst === e_dst) else begin
            miscompares++;
            $error("FAIL %s reg_dst observed=%0d expected=%0d", tag, o_reg_dst, e_dst);
        end
        assert (o_wb_ctl === e_wb) else begin
            miscompares++;
            $error("FAIL %s wb_ctl observed=%h expected=%h", tag, o_wb_ctl, e_wb);
        end
        assert (o_mem_ctl === e_mem) else begin
            miscompares++;
            $error("FAIL %s mem_ctl observed=%h expected=%h", tag, o_mem_ctl, e_mem);
        end
    endtask

    initial begin
        set_defaults();
        i_wb_ctl = 8'hFF; i_mem_ctl = 8'hFF;
        i_rst = 1'b1;
        step("reset", 32'd0, 32'd0, 5'd0, 8'h00, 8'h00);

        set_defaults();
        step("addu", 32'd22, 32'd7, 5'd9, 8'h00, 8'h00);

        // Immediate shifts: A = sign_ext = 5
        i_mux_rs_ctl = 2'b10;
        i_function = 6'b000000; step("sll", 32'd224, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b000010; step("srl", 32'd0, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b000011; i_rt_reg = 32'h8000_0000;
        step("sra", 32'hFC00_0000, 32'h8000_0000, 5'd9, 8'h00, 8'h00);
        i_function = 6'b000010;
        step("srl_msb", 32'h0400_0000, 32'h8000_0000, 5'd9, 8'h00, 8'h00);
        i_rt_reg = 32'd7; i_mux_rs_ctl = 2'b01;
        i_function = 6'b000100; step("sllv", 32'd229376, 32'd7, 5'd9, 8'h00, 8'h00);
        i_rt_reg = 32'h8000_0000;
        i_function = 6'b000111; step("srav", 32'hFFFF_0000, 32'h8000_0000, 5'd9, 8'h00, 8'h00);
        i_function = 6'b000110; step("srlv", 32'h0001_0000, 32'h8000_0000, 5'd9, 8'h00, 8'h00);
        i_rt_reg = 32'd7;

        // R-type sweep, A = rs, B = rt
        i_function = 6'b100011; step("subu", 32'd8, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b100100; step("and", 32'd7, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b100101; step("or", 32'd15, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b100110; step("xor", 32'd8, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b100111; step("nor", 32'hFFFF_FFF0, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b101010; i_rs_reg = 32'd256; i_rt_reg = 32'd10029;
        step("slt_lt", 32'd1, 32'd10029, 5'd9, 8'h00, 8'h00);
        i_rt_reg = 32'd17; step("slt_ge", 32'd0, 32'd17, 5'd9, 8'h00, 8'h00);
        i_rs_reg = 32'hFFFF_FFFF; i_rt_reg = 32'd1;
        step("slt_neg", 32'd1, 32'd1, 5'd9, 8'h00, 8'h00);
        i_rs_reg = 32'd0; i_rt_reg = 32'd1;
        i_function = 6'b100011; step("subu_wrap", 32'hFFFF_FFFF, 32'd1, 5'd9, 8'h00, 8'h00);
        i_rs_reg = 32'd15; i_rt_reg = 32'd7;
        i_function = 6'b001000; step("jr", 32'd0, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b001001; i_mux_rs_ctl = 2'b00;
        step("jalr", 32'd59, 32'd7, 5'd9, 8'h00, 8'h00);
        i_function = 6'b111111; i_mux_rs_ctl = 2'b01;
        step("bad_func", 32'd0, 32'd7, 5'd9, 8'h00, 8'h00);

        // Immediates: A = rs, B = sign_ext; store data stays forwarded rt
        i_mux_rt_ctl = 1'b1;
        i_alu_op_ctl = 4'b0000; step("addi", 32'd20, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b0001; step("sub", 32'd10, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b0100; step("andi", 32'd5, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b0101; step("ori", 32'd15, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b0110; step("xori", 32'd10, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b0111; step("lui", 32'h0005_0000, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b1000; step("none", 32'd0, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b0011; i_rs_reg = 32'd400; i_sign_ext = 32'd455;
        step("slti_lt", 32'd1, 32'd7, 5'd9, 8'h00, 8'h00);
        i_rs_reg = 32'd500; step("slti_ge", 32'd0, 32'd7, 5'd9, 8'h00, 8'h00);
        i_rs_reg = 32'd15; i_sign_ext = 32'd5;
        i_alu_op_ctl = 4'b1111; step("bad_op", 32'd0, 32'd7, 5'd9, 8'h00, 8'h00);
        i_alu_op_ctl = 4'b0000; i_mux_rs_ctl = 2'b11;
        step("a_zero", 32'd5, 32'd7, 5'd9, 8'h00, 8'h00);

        // JAL and destination select
        set_defaults();
        i_alu_op_ctl = 4'b1001; i_mux_rs_ctl = 2'b00; i_mux_dest_ctl = 2'b10;
        step("jal_31", 32'd59, 32'd7, 5'd31, 8'h00, 8'h00);
        i_mux_dest_ctl = 2'b01; step("jal_rt", 32'd59, 32'd7, 5'd4, 8'h00, 8'h00);
        i_mux_dest_ctl = 2'b11; step("dest_11", 32'd59, 32'd7, 5'd9, 8'h00, 8'h00);

        // Forwarding with ADDU
        set_defaults();
        i_mux_a_hz = 2'b01; i_ex_mem_reg_hz = 32'd100;
        step("fwd_a_exmem", 32'd107, 32'd7, 5'd9, 8'h00, 8'h00);
        i_mux_a_hz = 2'b00; i_mux_b_hz = 2'b10; i_mem_wb_reg_hz = 32'd3;
        step("fwd_b_memwb", 32'd18, 32'd3, 5'd9, 8'h00, 8'h00);
        i_mux_a_hz = 2'b10; i_mux_b_hz = 2'b01;
        step("fwd_swap", 32'd103, 32'd100, 5'd9, 8'h00, 8'h00);
        i_mux_a_hz = 2'b11; i_mux_b_hz = 2'b11;
        step("fwd_11", 32'd22, 32'd7, 5'd9, 8'h00, 8'h00);
        i_mux_a_hz = 2'b00; i_mux_b_hz = 2'b00;
        i_wb_ctl = 8'hA5; i_mem_ctl = 8'h3C;
        step("ctl_pass", 32'd22, 32'd7, 5'd9, 8'hA5, 8'h3C);

        // Reset mid-stream discards the in-flight instruction
        i_rst = 1'b1;
        step("reset_mid", 32'd0, 32'd0, 5'd0, 8'h00, 8'h00);
        i_rst = 1'b0;
        step("after_reset", 32'd22, 32'd7, 5'd9, 8'hA5, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
